seq_mult_nb: RTL and testbench
==============================

Name: seq_mult_nb

Overview:
- Parametrised sequential shift-and-add multiplier; successor to the fixed 5-bit button-driven multiplier.
- Operand width is generic. Control is a START/BUSY/DONE handshake instead of a button.
- Controller FSM and datapath (accumulator, multiplicand register, step counter) live in one module.
- Runs on the same slowed clock domain as the board-level wrappers; the top level provides debounce and clock division.

Parameters:
- N, 5, operand width in bits (N >= 2); PRODUCT is 2N bits.
- CW, $clog2(N+1), step-counter width.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  synchronous active-high reset.
- START  input  1  request a multiply; sampled only when the block is idle or in DONE.
- A  input  N  multiplicand; captured on the accepting edge.
- B  input  N  multiplier; captured on the accepting edge.
- BUSY  output  1  high while in RUN.
- DONE  output  1  one-cycle pulse when PRODUCT is valid and newly updated.
- PRODUCT  output  2N  result; holds its value until the next DONE.

Behaviour:
- Reset (RST=1 at an edge): state=IDLE, BUSY=0, DONE=0, PRODUCT=0, accumulator=0, counter=0. Reset overrides all other inputs, including mid-RUN; any partial result is discarded.
- States: IDLE, RUN, DONE.
- IDLE: if START=1, do all of the following, else stay in IDLE:
  - capture MCAND<=A;
  - load accumulator ACC (2N+1 bits) <= {(N+1)'b0, B};
  - counter<=0;
  - go to RUN.
- RUN: one step per clock, BUSY=1, START ignored.
  - Step: if ACC[0]=1, upper N+1 bits <= upper bits + {1'b0, MCAND}; then logical right shift of the whole ACC by 1. The add and shift happen in the same edge.
  - counter increments each step.
  - On the edge completing step N (counter==N-1): PRODUCT <= ACC[2N-1:0] after that step; go to DONE.
- DONE: DONE=1, BUSY=0, for exactly one cycle. If START=1 in this cycle, it is accepted exactly as in IDLE (back-to-back operation, next state RUN); else next state IDLE.
- Latency: DONE is high in the cycle beginning N edges after the START-accepting edge. Throughput is one result per N+1 cycles when back-to-back.
- PRODUCT changes only on the edge that enters DONE. It is stable during RUN and IDLE.
- Changes on A or B after capture have no effect on the operation in flight.
- Width rules:
  - the carry bit of ACC prevents overflow;
  - an unsigned product of (2^N-1)^2 fits in 2N bits with no truncation.
- Zero operands take the full N steps; there is no early exit.

Optional Feature:
- Macro SIGNED_MULT_EN.
- Defined: A and B are treated as two's complement.
  - ADD steps sign-extend MCAND to N+1 bits.
  - The right shift is arithmetic: ACC[2N] is replicated.
  - On step N, if ACC[0]=1 the upper bits are reduced by the sign-extended MCAND instead of increased by it.
  - PRODUCT is the 2N-bit two's-complement result.
  - Latency and handshake are unchanged.
- Undefined: unsigned-only operation as described under Behaviour; no extra logic is synthesised.

Test Plan:
- N=5, reset then START with A=13, B=11 -> BUSY=1 for 5 cycles; DONE pulses exactly 5 edges after acceptance; PRODUCT=143 (0x08F).
- N=5, A=31, B=31 -> PRODUCT=961 (0x3C1); A=0, B=31 -> PRODUCT=0 after the full 5-step latency.
- START held high continuously, A/B changed every cycle during RUN -> results correspond only to the operands captured at each accepting edge; DONE pulses every 6 cycles.
- RST asserted on the 3rd RUN cycle of 13*11 -> next cycle shows state IDLE, PRODUCT=0, BUSY=0, DONE=0. A new START for 7*9 then gives 63.
- START asserted while BUSY=1 -> ignored: no restart, and DONE timing is unchanged.
- With SIGNED_MULT_EN and N=5: A=-16 (0x10), B=15 -> PRODUCT=0x310 (-240); A=-1, B=-1 -> PRODUCT=1; A=-16, B=-16 -> PRODUCT=256 (0x100).

Source files
------------

// File: rtl/seq_mult_nb.sv
// seq_mult_nb: sequential shift-and-add multiplier with a START/BUSY/DONE handshake.
// One multiplier bit is retired per clock, so a result takes N steps after acceptance.
// Optional build macro SIGNED_MULT_EN: operands are two's complement, the right shift
// is arithmetic and the final (sign-bit) step subtracts the multiplicand.
module seq_mult_nb #(
  parameter int N  = 5,
  parameter int CW = $clog2(N + 1)
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           START,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  output logic           BUSY,
  output logic           DONE,
  output logic [2*N-1:0] PRODUCT
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [N-1:0]     mcand;
  // The extra top bit of acc is a carry (unsigned) or sign (signed) guard bit.
  logic [2*N:0]     acc;
  logic [CW-1:0]    cnt;
  logic [2*N-1:0]   product;

  logic             accept;
  logic             last_step;
  logic [N:0]       addend;
  logic [N:0]       upper_sum;
  logic [2*N:0]     acc_step;

  assign accept    = START && ((state == S_IDLE) || (state == S_DONE));
  assign last_step = (state == S_RUN) && (cnt == CW'(N - 1));
  assign PRODUCT   = product;

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and handshake outputs decoded from the state.
  always_comb begin
    state_nxt = state;
    BUSY      = 1'b0;
    DONE      = 1'b0;
    case (state)
      S_IDLE: begin
        if (START) state_nxt = S_RUN;
      end
      S_RUN: begin
        BUSY = 1'b1;
        if (cnt == CW'(N - 1)) state_nxt = S_DONE;
      end
      S_DONE: begin
        DONE      = 1'b1;
        state_nxt = START ? S_RUN : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // One shift-and-add step: conditional add into the upper half, then a right shift.
  always_comb begin
`ifdef SIGNED_MULT_EN
    addend = {mcand[N-1], mcand};
    if (acc[0])
      // The multiplier's sign bit has negative weight, so the last step subtracts.
      upper_sum = last_step ? (acc[2*N:N] - addend) : (acc[2*N:N] + addend);
    else
      upper_sum = acc[2*N:N];
    acc_step = {upper_sum[N], upper_sum, acc[N-1:1]};
`else
    addend    = {1'b0, mcand};
    upper_sum = acc[0] ? (acc[2*N:N] + addend) : acc[2*N:N];
    acc_step  = {1'b0, upper_sum, acc[N-1:1]};
`endif
  end

  // Multiplicand capture; held for the whole operation so later A changes are ignored.
  always_ff @(posedge CLK) begin
    if (accept) mcand <= A;
  end

  // Accumulator, step counter and result register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
    end else if (accept) begin
      acc <= {{(N + 1){1'b0}}, B};
      cnt <= '0;
    end else if (state == S_RUN) begin
      acc <= acc_step;
      cnt <= cnt + CW'(1);
      if (last_step) product <= acc_step[2*N-1:0];
    end
  end

endmodule

// File: tb/tb_seq_mult_nb.sv
// Directed bench for seq_mult_nb (N=5): handshake timing, products, reset, back-to-back.
module tb_seq_mult_nb;

  localparam int N = 5;

  logic           CLK = 1'b0;
  logic           RST;
  logic           START;
  logic [N-1:0]   A;
  logic [N-1:0]   B;
  logic           BUSY;
  logic           DONE;
  logic [2*N-1:0] PRODUCT;

  int checks = 0;
  int errors = 0;
  logic [2*N-1:0] prev_prod;

  seq_mult_nb #(.N(N)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .START   (START),
    .A       (A),
    .B       (B),
    .BUSY    (BUSY),
    .DONE    (DONE),
    .PRODUCT (PRODUCT)
  );

  always #5 CLK = ~CLK;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accept one operation at the next edge, watch N RUN cycles, and stop in the DONE cycle.
  task automatic op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                    input logic [2*N-1:0] exp, input logic keep_start, input logic noise);
    A     = a;
    B     = b;
    START = 1'b1;
    tick();
    START = keep_start;
    for (int i = 0; i < N; i++) begin
      check({tag, "_busy"}, 32'(BUSY), 32'd1);
      check({tag, "_nodone"}, 32'(DONE), 32'd0);
      check({tag, "_hold"}, 32'(PRODUCT), 32'(prev_prod));
      if (noise) begin
        A = N'($urandom);
        B = N'($urandom);
      end
      tick();
    end
    check({tag, "_done"}, 32'(DONE), 32'd1);
    check({tag, "_busy_lo"}, 32'(BUSY), 32'd0);
    check({tag, "_prod"}, 32'(PRODUCT), 32'(exp));
    prev_prod = exp;
  endtask

  task automatic go_idle(input string tag);
    START = 1'b0;
    tick();
    check({tag, "_idle_done"}, 32'(DONE), 32'd0);
    check({tag, "_idle_busy"}, 32'(BUSY), 32'd0);
    check({tag, "_idle_prod"}, 32'(PRODUCT), 32'(prev_prod));
  endtask

  initial begin
    RST       = 1'b1;
    START     = 1'b0;
    A         = '0;
    B         = '0;
    prev_prod = '0;
    tick();
    tick();
    RST = 1'b0;
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_done", 32'(DONE), 32'd0);
    check("rst_prod", 32'(PRODUCT), 32'd0);

`ifdef SIGNED_MULT_EN
    op("s_m16x15", 5'h10, 5'd15, 10'h310, 1'b0, 1'b1);
    go_idle("s_m16x15");
    op("s_m1xm1", 5'h1f, 5'h1f, 10'h001, 1'b0, 1'b0);
    go_idle("s_m1xm1");
    op("s_m16xm16", 5'h10, 5'h10, 10'h100, 1'b0, 1'b0);
    go_idle("s_m16xm16");
`else
    op("u13x11", 5'd13, 5'd11, 10'd143, 1'b0, 1'b0);
    go_idle("u13x11");
    op("u31x31", 5'd31, 5'd31, 10'd961, 1'b0, 1'b0);
    go_idle("u31x31");
    op("u0x31", 5'd0, 5'd31, 10'd0, 1'b0, 1'b0);
    go_idle("u0x31");

    // START held high through RUN is ignored; operands wiggle after capture.
    op("ign7x9", 5'd7, 5'd9, 10'd63, 1'b1, 1'b1);
    go_idle("ign7x9");

    // Back-to-back: START never drops, each DONE cycle accepts the next operands.
    op("b2b_3x5", 5'd3, 5'd5, 10'd15, 1'b1, 1'b1);
    op("b2b_6x7", 5'd6, 5'd7, 10'd42, 1'b1, 1'b1);
    op("b2b_2x9", 5'd2, 5'd9, 10'd18, 1'b1, 1'b1);
    go_idle("b2b");

    // Reset in the third RUN cycle discards the operation in flight.
    A     = 5'd13;
    B     = 5'd11;
    START = 1'b1;
    tick();
    START = 1'b0;
    tick();
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    prev_prod = '0;
    check("mrst_busy", 32'(BUSY), 32'd0);
    check("mrst_done", 32'(DONE), 32'd0);
    check("mrst_prod", 32'(PRODUCT), 32'd0);
    for (int i = 0; i < N + 1; i++) begin
      tick();
      check("mrst_stay_idle", 32'(BUSY | DONE), 32'd0);
    end
    op("post_rst_7x9", 5'd7, 5'd9, 10'd63, 1'b0, 1'b0);
    go_idle("post_rst_7x9");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
